lsu_mem_ctrl: RTL and testbench



---
 rtl/lsu_mem_ctrl_pkg.sv | 24 ++
 rtl/lsu_mem_ctrl_if.sv | 27 ++
 rtl/lsu_extend.sv | 34 +++
 rtl/lsu_mem_ctrl.sv | 178 +++++++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_mem_ctrl_pkg.sv
// Shared types and constants for the load/store unit: access-size encoding,
// FSM state enum and default datapath widths.
package lsu_mem_ctrl_pkg;

   localparam int XLEN_DEF = 19;
   localparam int ALEN_DEF = 19;

   localparam logic [1:0] BYTE      = 2'b00;
   localparam logic [1:0] HALF_WORD = 2'b01;
   localparam logic [1:0] WORD      = 2'b10;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      REQ  = 2'b01,
      WAIT = 2'b10,
      DONE = 2'b11
   } lsu_state_t;

   // The reserved size code behaves as a full word everywhere, including on the bus.
   function automatic logic [1:0] norm_size(input logic [1:0] size);
      return (size == 2'b11) ? WORD : size;
   endfunction

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// Data-memory bus between the load/store unit (master) and word-addressed
// memory (slave): req/gnt request phase, rvalid response phase.
interface lsu_mem_ctrl_if #(
   parameter int XLEN = lsu_mem_ctrl_pkg::XLEN_DEF,
   parameter int ALEN = lsu_mem_ctrl_pkg::ALEN_DEF
);

   logic            mem_req_o;
   logic            mem_we_o;
   logic [1:0]      mem_size_o;
   logic [ALEN-1:0] mem_addr_o;
   logic [XLEN-1:0] mem_wdata_o;
   logic            mem_gnt_i;
   logic            mem_rvalid_i;
   logic [XLEN-1:0] mem_rdata_i;

   modport master (
      output mem_req_o, mem_we_o, mem_size_o, mem_addr_o, mem_wdata_o,
      input  mem_gnt_i, mem_rvalid_i, mem_rdata_i
   );

   modport slave (
      input  mem_req_o, mem_we_o, mem_size_o, mem_addr_o, mem_wdata_o,
      output mem_gnt_i, mem_rvalid_i, mem_rdata_i
   );

endinterface

// File: rtl/lsu_extend.sv
// Size/extension unit: keeps the low byte, half-word or full word of i_data and
// fills the upper bits with zeros (i_zext = 1) or the sign bit (i_zext = 0).
module lsu_extend
   import lsu_mem_ctrl_pkg::*;
#(
   parameter int XLEN = XLEN_DEF
) (
   input  logic [1:0]      i_size,
   input  logic            i_zext,
   input  logic [XLEN-1:0] i_data,
   output logic [XLEN-1:0] o_data
);

   logic w_fill;

   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so no
      // branch can leave it unassigned and infer a latch.
      w_fill = 1'b0;
      o_data = i_data;
      case (i_size)
         BYTE: begin
            w_fill = ~i_zext & i_data[7];
            o_data = {{(XLEN-8){w_fill}}, i_data[7:0]};
         end
         HALF_WORD: begin
            w_fill = ~i_zext & i_data[15];
            o_data = {{(XLEN-16){w_fill}}, i_data[15:0]};
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Multi-cycle load/store unit: latches a decoder access, runs req/gnt/rvalid to
// data memory, stalls the pipeline until DONE. Optional watchdog: LSU_TIMEOUT_EN.
module lsu_mem_ctrl
   import lsu_mem_ctrl_pkg::*;
#(
   parameter int XLEN = XLEN_DEF,
   parameter int ALEN = ALEN_DEF
`ifdef LSU_TIMEOUT_EN
   ,parameter int TIMEOUT_CYC = 64
`endif
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            data_req_i,
   input  logic            data_wr_i,
   input  logic [1:0]      data_byte_i,
   input  logic            zero_extnd_i,
   input  logic [ALEN-1:0] addr_i,
   input  logic [XLEN-1:0] wdata_i,
   output logic            stall_o,
   output logic [XLEN-1:0] rdata_o,
   output logic            rdata_valid_o,
   lsu_mem_ctrl_if.master  mem,
   output logic            err_o
);

   lsu_state_t      r_state;
   lsu_state_t      w_next_state;
   logic            w_resp;
   logic            w_timeout;

   logic            r_wr;
   logic [1:0]      r_size;
   logic            r_zext;
   logic [ALEN-1:0] r_addr;
   logic [XLEN-1:0] r_wdata;
   logic [XLEN-1:0] r_rdata;
   logic            r_rdata_valid;

   logic [1:0]      w_req_size;
   logic [XLEN-1:0] w_wdata_masked;
   logic [XLEN-1:0] w_rdata_ext;

   assign w_req_size = norm_size(data_byte_i);

   lsu_extend #(.XLEN(XLEN)) u_store_mask (
      .i_size (w_req_size),
      .i_zext (1'b1),
      .i_data (wdata_i),
      .o_data (w_wdata_masked)
   );

   lsu_extend #(.XLEN(XLEN)) u_load_ext (
      .i_size (r_size),
      .i_zext (r_zext),
      .i_data (mem.mem_rdata_i),
      .o_data (w_rdata_ext)
   );

`ifdef LSU_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

   logic [CNT_W-1:0] r_cnt;
   logic             r_err;

   assign w_timeout = ((r_state == REQ) || (r_state == WAIT)) && !w_resp &&
                      (r_cnt == CNT_W'(TIMEOUT_CYC - 1));

   // Counter idles at zero, so it starts from zero on every entry to REQ.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt <= '0;
         r_err <= 1'b0;
      end else begin
         if ((r_state == REQ) || (r_state == WAIT)) begin
            r_cnt <= r_cnt + 1'b1;
         end else begin
            r_cnt <= '0;
         end
         if (w_timeout) begin
            r_err <= 1'b1;
         end
      end
   end

   assign err_o = r_err;
`else
   assign w_timeout = 1'b0;
   assign err_o     = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      w_resp       = 1'b0;
      case (r_state)
         IDLE: begin
            if (data_req_i) begin
               w_next_state = REQ;
            end
         end
         REQ: begin
            if (mem.mem_gnt_i && mem.mem_rvalid_i) begin
               w_next_state = DONE;
               w_resp       = 1'b1;
            end else if (mem.mem_gnt_i) begin
               w_next_state = WAIT;
            end
         end
         WAIT: begin
            if (mem.mem_rvalid_i) begin
               w_next_state = DONE;
               w_resp       = 1'b1;
            end
         end
         DONE: begin
            w_next_state = IDLE;
         end
         default: begin
            w_next_state = IDLE;
         end
      endcase
      if (w_timeout) begin
         w_next_state = DONE;
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state is written with non-blocking assignments so every
      // register in this block samples the values from before the edge.
      if (reset) begin
         r_wr          <= 1'b0;
         r_size        <= BYTE;
         r_zext        <= 1'b0;
         r_addr        <= '0;
         r_wdata       <= '0;
         r_rdata       <= '0;
         r_rdata_valid <= 1'b0;
      end else begin
         r_rdata_valid <= 1'b0;
         if ((r_state == IDLE) && data_req_i) begin
            r_wr    <= data_wr_i;
            r_size  <= w_req_size;
            r_zext  <= zero_extnd_i;
            r_addr  <= addr_i;
            r_wdata <= w_wdata_masked;
         end
         // Stores complete silently; rdata_o keeps the last load result.
         if (w_resp && !r_wr) begin
            r_rdata       <= w_rdata_ext;
            r_rdata_valid <= 1'b1;
         end
         if (w_timeout && !r_wr) begin
            r_rdata       <= '0;
            r_rdata_valid <= 1'b1;
         end
      end
   end

   // Request drops in the same cycle reset is raised, not one edge later.
   assign mem.mem_req_o   = (r_state == REQ) && !reset;
   assign mem.mem_we_o    = r_wr;
   assign mem.mem_size_o  = r_size;
   assign mem.mem_addr_o  = r_addr;
   assign mem.mem_wdata_o = r_wdata;

   assign stall_o       = data_req_i && (r_state != DONE);
   assign rdata_o       = r_rdata;
   assign rdata_valid_o = r_rdata_valid;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl: directed plan cases plus randomized
// accesses against a transaction-level reference model and reactive memory.
module tb_lsu_mem_ctrl;

   localparam int XLEN = 19;
   localparam int ALEN = 19;
`ifdef LSU_TIMEOUT_EN
   localparam int TO_CYC = 8;
`endif

   typedef struct {
      bit              wr;
      logic [1:0]      size;
      bit              zext;
      logic [ALEN-1:0] addr;
      logic [XLEN-1:0] wdata;
      logic [XLEN-1:0] rdata;
      int              gnt_dly;
      int              rv_dly;
      bit              keep_req;
   } tx_t;

   logic            clk = 1'b0;
   logic            reset;
   logic            data_req;
   logic            data_wr;
   logic [1:0]      data_byte;
   logic            zext;
   logic [ALEN-1:0] addr;
   logic [XLEN-1:0] wdata;
   logic            stall;
   logic [XLEN-1:0] rdata;
   logic            rdata_valid;
   logic            err;

   int              n_checks = 0;
   int              n_errors = 0;
   logic [31:0]     exp_rdata = 32'd0;
   logic [31:0]     exp_err = 32'd0;

   lsu_mem_ctrl_if #(.XLEN(XLEN), .ALEN(ALEN)) mem_if ();

   lsu_mem_ctrl #(
      .XLEN (XLEN),
      .ALEN (ALEN)
`ifdef LSU_TIMEOUT_EN
      ,.TIMEOUT_CYC (TO_CYC)
`endif
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .data_req_i    (data_req),
      .data_wr_i     (data_wr),
      .data_byte_i   (data_byte),
      .zero_extnd_i  (zext),
      .addr_i        (addr),
      .wdata_i       (wdata),
      .stall_o       (stall),
      .rdata_o       (rdata),
      .rdata_valid_o (rdata_valid),
      .mem           (mem_if.master),
      .err_o         (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference: keep the low 8/16 bits, sign-extend by adding the top offset when negative.
   function automatic logic [31:0] ref_load(input logic [1:0] size, input bit zx,
                                            input logic [31:0] raw);
      int unsigned v;
      case (size)
         2'd0: begin
            v = raw % 256;
            if (!zx && v >= 128) v = v + (2 ** XLEN) - 256;
         end
         2'd1: begin
            v = raw % 65536;
            if (!zx && v >= 32768) v = v + (2 ** XLEN) - 65536;
         end
         default: v = raw;
      endcase
      return v;
   endfunction

   function automatic logic [31:0] ref_store(input logic [1:0] size, input logic [31:0] raw);
      case (size)
         2'd0:    return raw % 256;
         2'd1:    return raw % 65536;
         default: return raw;
      endcase
   endfunction

   function automatic tx_t mk(input bit wr, input logic [1:0] size, input bit zx,
                              input logic [ALEN-1:0] a, input logic [XLEN-1:0] wd,
                              input logic [XLEN-1:0] rd, input int g, input int r,
                              input bit keep);
      tx_t t;
      t.wr = wr; t.size = size; t.zext = zx; t.addr = a; t.wdata = wd;
      t.rdata = rd; t.gnt_dly = g; t.rv_dly = r; t.keep_req = keep;
      return t;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_cycle();
      data_req              = 1'b0;
      mem_if.mem_gnt_i      = 1'b0;
      mem_if.mem_rvalid_i   = 1'($urandom_range(0, 1));
      mem_if.mem_rdata_i    = XLEN'($urandom);
      #1;
      check("idle_gap_stall", stall, 0);
      check("idle_gap_req", mem_if.mem_req_o, 0);
      check("idle_gap_valid", rdata_valid, 0);
      check("idle_gap_rdata", rdata, exp_rdata);
      step();
   endtask

   // Drives one access as decoder + memory and checks every cycle of it.
   task automatic run_access(input tx_t t);
      logic [1:0]  exp_sz;
      logic [31:0] exp_wd;
      exp_sz = (t.size == 2'b11) ? 2'b10 : t.size;
      exp_wd = ref_store(exp_sz, 32'(t.wdata));

      data_req = 1'b1; data_wr = t.wr; data_byte = t.size; zext = t.zext;
      addr = t.addr; wdata = t.wdata;
      mem_if.mem_gnt_i    = 1'b0;
      mem_if.mem_rvalid_i = 1'($urandom_range(0, 1));
      mem_if.mem_rdata_i  = XLEN'($urandom);
      #1;
      check("idle_stall", stall, 1);
      check("idle_req", mem_if.mem_req_o, 0);
      check("idle_valid", rdata_valid, 0);
      step();

      for (int k = 0; k <= t.gnt_dly; k++) begin
         data_wr = 1'($urandom); data_byte = 2'($urandom); zext = 1'($urandom);
         addr = ALEN'($urandom); wdata = XLEN'($urandom);
         mem_if.mem_gnt_i = (k == t.gnt_dly);
         if (k == t.gnt_dly) mem_if.mem_rvalid_i = (t.rv_dly == 0);
         else                mem_if.mem_rvalid_i = 1'($urandom_range(0, 1));
         mem_if.mem_rdata_i = (mem_if.mem_gnt_i && mem_if.mem_rvalid_i) ? t.rdata : XLEN'($urandom);
         #1;
         check("req_stall", stall, 1);
         check("req_req", mem_if.mem_req_o, 1);
         check("req_we", mem_if.mem_we_o, t.wr);
         check("req_size", mem_if.mem_size_o, exp_sz);
         check("req_addr", mem_if.mem_addr_o, t.addr);
         check("req_wdata", mem_if.mem_wdata_o, exp_wd);
         step();
      end

      for (int j = 1; j <= t.rv_dly; j++) begin
         mem_if.mem_gnt_i    = 1'b0;
         mem_if.mem_rvalid_i = (j == t.rv_dly);
         mem_if.mem_rdata_i  = (j == t.rv_dly) ? t.rdata : XLEN'($urandom);
         #1;
         check("wait_stall", stall, 1);
         check("wait_req", mem_if.mem_req_o, 0);
         step();
      end

      data_req            = t.keep_req;
      mem_if.mem_gnt_i    = 1'b0;
      mem_if.mem_rvalid_i = 1'b0;
      if (!t.wr) exp_rdata = ref_load(exp_sz, t.zext, 32'(t.rdata));
      #1;
      check("done_stall", stall, 0);
      check("done_valid", rdata_valid, !t.wr);
      check("done_rdata", rdata, exp_rdata);
      check("done_err", err, exp_err);
      step();
      check("post_valid", rdata_valid, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      tx_t t;
      reset = 1'b1; data_req = 1'b0; data_wr = 1'b0; data_byte = 2'b00; zext = 1'b0;
      addr = '0; wdata = '0;
      mem_if.mem_gnt_i = 1'b0; mem_if.mem_rvalid_i = 1'b0; mem_if.mem_rdata_i = '0;
      step();
      step();
      check("rst_req", mem_if.mem_req_o, 0);
      check("rst_we", mem_if.mem_we_o, 0);
      check("rst_size", mem_if.mem_size_o, 0);
      check("rst_addr", mem_if.mem_addr_o, 0);
      check("rst_wdata", mem_if.mem_wdata_o, 0);
      check("rst_rdata", rdata, 0);
      check("rst_valid", rdata_valid, 0);
      check("rst_stall", stall, 0);
      check("rst_err", err, 0);
      reset = 1'b0;
      step();

      // Word load, zero-wait memory.
      run_access(mk(1'b0, 2'b10, 1'b0, 19'h00010, 19'h0, 19'h5A5A5, 0, 0, 1'b0));
      idle_cycle();
      // Signed byte load, then zero-extended.
      run_access(mk(1'b0, 2'b00, 1'b0, 19'h00020, 19'h0, 19'h00080, 0, 1, 1'b0));
      run_access(mk(1'b0, 2'b00, 1'b1, 19'h00024, 19'h0, 19'h00080, 1, 0, 1'b0));
      idle_cycle();
      // Half-word store with wait states: gnt after 3 cycles, rvalid 2 after gnt.
      run_access(mk(1'b1, 2'b01, 1'b0, 19'h00100, 19'h7ABCD, 19'h0, 3, 2, 1'b0));
      idle_cycle();
      // Back-to-back loads, request held high through DONE.
      run_access(mk(1'b0, 2'b01, 1'b0, 19'h00200, 19'h0, 19'h18001, 0, 0, 1'b1));
      run_access(mk(1'b0, 2'b11, 1'b0, 19'h00204, 19'h0, 19'h4C3B2, 1, 1, 1'b0));
      idle_cycle();

      // Reset while in WAIT, rvalid arriving one cycle later.
      data_req = 1'b1; data_wr = 1'b0; data_byte = 2'b10; zext = 1'b0;
      addr = 19'h00300; wdata = '0;
      step();
      mem_if.mem_gnt_i = 1'b1; mem_if.mem_rvalid_i = 1'b0;
      step();
      mem_if.mem_gnt_i = 1'b0; data_req = 1'b0; reset = 1'b1;
      #1;
      check("midrst_req_drop", mem_if.mem_req_o, 0);
      step();
      reset = 1'b0; mem_if.mem_rvalid_i = 1'b1; mem_if.mem_rdata_i = 19'h12345;
      exp_rdata = 32'd0;
      #1;
      check("midrst_req", mem_if.mem_req_o, 0);
      check("midrst_we", mem_if.mem_we_o, 0);
      check("midrst_size", mem_if.mem_size_o, 0);
      check("midrst_addr", mem_if.mem_addr_o, 0);
      check("midrst_wdata", mem_if.mem_wdata_o, 0);
      check("midrst_rdata", rdata, 0);
      check("midrst_valid", rdata_valid, 0);
      check("midrst_stall", stall, 0);
      step();
      mem_if.mem_rvalid_i = 1'b0;
      #1;
      check("late_rvalid_valid", rdata_valid, 0);
      check("late_rvalid_rdata", rdata, 0);
      step();

      // Randomized accesses.
      for (int n = 0; n < 40; n++) begin
         t = mk(1'($urandom), 2'($urandom), 1'($urandom), ALEN'($urandom), XLEN'($urandom),
                XLEN'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                1'($urandom));
         run_access(t);
         if (!t.keep_req) begin
            for (int g = $urandom_range(0, 2); g > 0; g--) idle_cycle();
         end
      end
      idle_cycle();

`ifdef LSU_TIMEOUT_EN
      // Granted load whose rvalid never arrives: forced DONE after TO_CYC cycles.
      data_req = 1'b1; data_wr = 1'b0; data_byte = 2'b10; zext = 1'b0;
      addr = 19'h00400; wdata = '0;
      step();
      for (int c = 0; c < TO_CYC; c++) begin
         mem_if.mem_gnt_i    = (c == 0);
         mem_if.mem_rvalid_i = 1'b0;
         #1;
         check("to_stall", stall, 1);
         check("to_err_pre", err, 0);
         step();
      end
      mem_if.mem_gnt_i = 1'b0; data_req = 1'b0;
      exp_rdata = 32'd0; exp_err = 32'd1;
      #1;
      check("to_done_valid", rdata_valid, 1);
      check("to_done_rdata", rdata, 0);
      check("to_done_err", err, 1);
      step();
      idle_cycle();
      check("to_err_sticky", err, 1);
      run_access(mk(1'b0, 2'b10, 1'b0, 19'h00404, 19'h0, 19'h2AAAA, 0, 0, 1'b0));
      check("to_err_sticky2", err, 1);
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
